// File: rtl/uart_hex_tx.sv
// Byte-to-ASCII-hex UART transmitter: prints one accepted byte as two uppercase
// hex characters (optionally followed by CR LF) on an 8N1 serial line.
module uart_hex_tx #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned SEND_CRLF    = 1
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Byte_DV,
    input  logic [7:0] i_Byte,
    output logic       o_Ready,
    output logic       o_TX_Serial,
    output logic       o_TX_Active,
    output logic       o_Done
);

    localparam int unsigned   CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    LAST_IDX  = (SEND_CRLF != 0) ? 2'd3 : 2'd1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]    state;
    logic [7:0]    hold_byte;
    logic [1:0]    char_idx;
    logic [2:0]    bit_idx;
    logic [CW-1:0] baud_cnt;
    logic          done;
    logic [7:0]    cur_char;
    logic          serial;
    logic          baud_end;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_comb begin
        cur_char = 8'h0D;
        case (char_idx)
            2'd0:    cur_char = hex_ascii(hold_byte[7:4]);
            2'd1:    cur_char = hex_ascii(hold_byte[3:0]);
            2'd2:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    // Line is decoded from registered state, so an async reset forces it high at once.
    always_comb begin
        serial = 1'b1;
        case (state)
            START:   serial = 1'b0;
            DATA:    serial = cur_char[bit_idx];
            default: serial = 1'b1;
        endcase
    end

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state     <= IDLE;
            hold_byte <= '0;
            char_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (i_Byte_DV) begin
                        hold_byte <= i_Byte;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (char_idx < LAST_IDX) begin
                            char_idx <= char_idx + 2'd1;
                            state    <= START;
                        end else begin
                            char_idx <= '0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_Ready     = (state == IDLE);
    assign o_TX_Active = (state != IDLE);
    assign o_TX_Serial = serial;
    assign o_Done      = done;

endmodule
